// File: rtl/instr_fetch_if.sv
// Instruction-memory read port: fetch unit drives request/address, memory returns ack/data.
interface instr_fetch_if;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 32;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_data;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_data);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_data);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: sequential PC fetch, consumer stall handshake and branch redirect
// with squashing of a fetch that is already in flight.
module instr_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  instr_fetch_if.master        imem,
  output logic [31:0]          instr,
  output logic [63:0]          instr_pc,
  output logic                 instr_valid,
  input  logic                 stall,
  input  logic                 br_taken,
  input  logic                 uncond_br,
  input  logic [63:0]          br_pc,
  input  logic [25:0]          br_addr26,
  input  logic [18:0]          cond_addr19
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t          state, nxt_state;
  logic [XLEN-1:0] pc, nxt_pc;
  logic            squash, nxt_squash;
  logic [XLEN-1:0] stale_addr, nxt_stale_addr;
  logic [ILEN-1:0] nxt_instr;
  logic [XLEN-1:0] nxt_instr_pc;
  logic            nxt_instr_valid;
  logic [XLEN-1:0] br_off;
  logic [XLEN-1:0] target;

  // A squashed request keeps its original address on the bus until its ack returns.
  assign imem.imem_req  = (state == REQ);
  assign imem.imem_addr = squash ? stale_addr : pc;

  always_comb begin
    br_off = uncond_br ? {{(XLEN-26){br_addr26[25]}}, br_addr26}
                       : {{(XLEN-19){cond_addr19[18]}}, cond_addr19};
    target = br_pc + (br_off << 2);
  end

  always_comb begin
    nxt_state       = state;
    nxt_pc          = pc;
    nxt_squash      = squash;
    nxt_stale_addr  = stale_addr;
    nxt_instr       = instr;
    nxt_instr_pc    = instr_pc;
    nxt_instr_valid = instr_valid & stall;

    if (br_taken) begin
      nxt_pc          = target;
      nxt_instr_valid = 1'b0;
      nxt_state       = REQ;
      if (state == REQ && !imem.imem_ack) begin
        nxt_squash = 1'b1;
        if (!squash) nxt_stale_addr = pc;
      end else begin
        nxt_squash = 1'b0;
      end
    end else begin
      case (state)
        IDLE: nxt_state = REQ;
        REQ: begin
          if (imem.imem_ack) begin
            if (squash) begin
              nxt_squash = 1'b0;
            end else begin
              nxt_instr       = imem.imem_data;
              nxt_instr_pc    = pc;
              nxt_instr_valid = 1'b1;
              nxt_pc          = pc + XLEN'(4);
              nxt_state       = stall ? HOLD : REQ;
            end
          end
        end
        HOLD: if (!stall) nxt_state = REQ;
        default: nxt_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      squash      <= 1'b0;
      stale_addr  <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= nxt_state;
      pc          <= nxt_pc;
      squash      <= nxt_squash;
      stale_addr  <= nxt_stale_addr;
      instr       <= nxt_instr;
      instr_pc    <= nxt_instr_pc;
      instr_valid <= nxt_instr_valid;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios then random traffic, checked against a
// transaction-level fetch model.
module tb_instr_fetch;

  localparam logic [63:0] RST_PC = 64'h0;

  logic        clk;
  logic        reset_n;
  logic        stall, br_taken, uncond_br;
  logic [63:0] br_pc;
  logic [25:0] br_addr26;
  logic [18:0] cond_addr19;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_valid;
  logic        ack;
  logic [31:0] data;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  instr_fetch_if imem_bus ();
  assign imem_bus.imem_ack  = ack;
  assign imem_bus.imem_data = data;

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .imem       (imem_bus),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .stall      (stall),
    .br_taken   (br_taken),
    .uncond_br  (uncond_br),
    .br_pc      (br_pc),
    .br_addr26  (br_addr26),
    .cond_addr19(cond_addr19)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: fetch address, whether a request is on the bus, pending-discard bookkeeping.
  logic [63:0] m_pc, m_stale, m_ipc;
  logic [31:0] m_instr;
  bit          m_wake, m_fetch, m_discard, m_valid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_stale = '0; m_ipc = '0; m_instr = '0;
    m_wake = 1'b1; m_fetch = 1'b0; m_discard = 1'b0; m_valid = 1'b0;
  endtask

  task automatic model_step();
    longint      off;
    logic [63:0] tgt;
    off = uncond_br ? longint'($signed(br_addr26)) : longint'($signed(cond_addr19));
    tgt = br_pc + 64'(off * 4);
    if (br_taken) begin
      if (m_fetch && !ack) begin
        if (!m_discard) m_stale = m_pc;
        m_discard = 1'b1;
      end else begin
        m_discard = 1'b0;
      end
      m_pc = tgt; m_fetch = 1'b1; m_wake = 1'b0; m_valid = 1'b0;
    end else begin
      m_valid = m_valid && stall;
      if (m_wake) begin
        m_wake = 1'b0; m_fetch = 1'b1;
      end else if (m_fetch) begin
        if (ack) begin
          if (m_discard) m_discard = 1'b0;
          else begin
            m_instr = data; m_ipc = m_pc; m_valid = 1'b1;
            m_pc = m_pc + 64'd4; m_fetch = !stall;
          end
        end
      end else if (!stall) begin
        m_fetch = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".req"},   64'(imem_bus.imem_req), 64'(m_fetch));
    chk({tag, ".addr"},  imem_bus.imem_addr, m_discard ? m_stale : m_pc);
    chk({tag, ".valid"}, 64'(instr_valid), 64'(m_valid));
    chk({tag, ".instr"}, 64'(instr), 64'(m_instr));
    chk({tag, ".ipc"},   instr_pc, m_ipc);
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset asserted mid-cycle with a stray ack on the bus.
  task automatic apply_reset();
    #3;
    reset_n = 1'b0;
    ack = 1'b1;
    data = $urandom;
    #1;
    model_reset();
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    reset_n = 1'b1;
    ack = 1'b0;
  endtask

  task automatic idle_inputs();
    stall = 1'b0; br_taken = 1'b0; uncond_br = 1'b0;
    br_pc = '0; br_addr26 = '0; cond_addr19 = '0; ack = 1'b0; data = '0;
  endtask

  initial begin
    logic [31:0] w;
    reset_n = 1'b0;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    apply_reset();

    // Straight-line fetch with single-cycle ack.
    tick("idle2req");
    chk("first_req", 64'(imem_bus.imem_req), 64'd1);
    chk("first_addr", imem_bus.imem_addr, RST_PC);
    ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = $urandom; data = w;
      tick("seq");
      chk("seq_pc", instr_pc, 64'(i * 4));
      chk("seq_instr", 64'(instr), 64'(w));
    end

    // Consumer stall while holding the instruction at pc 8.
    apply_reset();
    tick("idle2req_b");
    ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data = $urandom;
      stall = (i == 2);
      tick("pre_hold");
    end
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1; ack = 1'b1; data = $urandom;
      tick("hold");
      chk("hold_req", 64'(imem_bus.imem_req), 64'd0);
      chk("hold_pc", instr_pc, 64'h8);
    end
    stall = 1'b0; ack = 1'b0;
    tick("hold_release");
    chk("release_addr", imem_bus.imem_addr, 64'hC);
    chk("release_req", 64'(imem_bus.imem_req), 64'd1);

    // Unconditional branch coinciding with an ack.
    ack = 1'b1; data = $urandom;
    br_taken = 1'b1; uncond_br = 1'b1; br_pc = 64'h100; br_addr26 = 26'h3FF_FFFE;
    tick("br_uncond");
    chk("br_uncond_addr", imem_bus.imem_addr, 64'hF8);
    chk("br_uncond_valid", 64'(instr_valid), 64'd0);
    br_taken = 1'b0;

    // Conditional branch while an ack is outstanding for two cycles.
    ack = 1'b0;
    br_taken = 1'b1; uncond_br = 1'b0; br_pc = 64'h40; cond_addr19 = 19'd5;
    tick("br_cond");
    chk("squash_addr", imem_bus.imem_addr, 64'hF8);
    br_taken = 1'b0;
    tick("squash_wait");
    ack = 1'b1; data = $urandom;
    tick("squash_ack");
    chk("squash_valid", 64'(instr_valid), 64'd0);
    chk("squash_next", imem_bus.imem_addr, 64'h54);
    data = $urandom;
    tick("after_squash");
    chk("after_squash_pc", instr_pc, 64'h54);

    // PC increment and branch target wrap at 2^64.
    br_taken = 1'b1; uncond_br = 1'b0; br_pc = 64'hFFFF_FFFF_FFFF_FFF8; cond_addr19 = 19'd1;
    tick("br_top");
    chk("top_addr", imem_bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    br_taken = 1'b0; data = $urandom;
    tick("wrap_inc");
    chk("wrap_inc_addr", imem_bus.imem_addr, 64'h0);
    br_taken = 1'b1; uncond_br = 1'b1; br_addr26 = 26'd4;
    tick("wrap_tgt");
    chk("wrap_tgt_addr", imem_bus.imem_addr, 64'h8);
    br_taken = 1'b0;

    // Random traffic including acks without a request.
    for (int i = 0; i < 600; i++) begin
      ack         = ($urandom_range(0, 2) != 0);
      data        = $urandom;
      stall       = ($urandom_range(0, 3) == 0);
      br_taken    = ($urandom_range(0, 9) == 0);
      uncond_br   = $urandom_range(0, 1) == 1;
      br_pc       = {$urandom, $urandom} & ~64'h3;
      br_addr26   = 26'($urandom);
      cond_addr19 = 19'($urandom);
      tick("rand");
    end

    // Reset while a request is pending, with a stray ack during reset.
    idle_inputs();
    br_taken = 1'b1; br_pc = 64'h200;
    tick("pre_rst_br");
    br_taken = 1'b0;
    tick("pre_rst_wait");
    chk("pre_rst_req", 64'(imem_bus.imem_req), 64'd1);
    apply_reset();
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_addr", imem_bus.imem_addr, RST_PC);
    tick("post_rst_idle");
    chk("post_rst_req", 64'(imem_bus.imem_req), 64'd1);
    chk("post_rst_addr", imem_bus.imem_addr, RST_PC);
    ack = 1'b1; data = $urandom;
    tick("post_rst_fetch");
    chk("post_rst_ipc", instr_pc, RST_PC);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
